// File: rtl/if_pc_unit.sv
// IF-stage program counter and fetch control, aligned with a one-cycle registered instruction memory.
// Optional misaligned-redirect trap (HALT state, fetch_fault) is enabled by defining FETCH_MISALIGN_TRAP_EN.
module if_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] if_pc_r;
  logic [31:0] if_pc_s;
  logic [31:0] if_pc_plus4_r;
  logic [31:0] if_pc_plus4_s;
  logic        if_valid_r;
  logic        if_valid_s;
  logic        fetch_fault_r;
  logic        fetch_fault_s;
  logic [31:0] target_aligned_s;
  logic [31:0] pc_plus4_s;

  assign target_aligned_s = redirect_target & 32'hFFFF_FFFC;
  assign pc_plus4_s       = pc_r + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      BOOT: begin
        if (stall) begin
          state_s = BOOT;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect && (redirect_target[1:0] != 2'b00)) begin
          state_s = HALT;
        end else begin
          state_s = RUN;
        end
`else
        state_s = RUN;
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT:    state_s = HALT;
`endif
      default: state_s = BOOT;
    endcase
  end

  // Next values of the fetch address and the IF/ID-facing outputs
  always_comb begin
    pc_s          = pc_r;
    if_pc_s       = if_pc_r;
    if_pc_plus4_s = if_pc_plus4_r;
    if_valid_s    = if_valid_r;
    fetch_fault_s = fetch_fault_r;
    case (state_r)
      BOOT: begin
        if (!stall) begin
          if_pc_s       = pc_r;
          if_pc_plus4_s = pc_plus4_s;
          if_valid_s    = 1'b1;
          pc_s          = pc_plus4_s;
        end else begin
          if_valid_s    = 1'b0;
        end
      end
      RUN: begin
        if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect_target[1:0] != 2'b00) begin
            if_valid_s    = 1'b0;
            fetch_fault_s = 1'b1;
          end else begin
            if_pc_s       = pc_r;
            if_pc_plus4_s = pc_plus4_s;
            if_valid_s    = 1'b0;
            pc_s          = target_aligned_s;
          end
`else
          // The word read at this edge is wrong-path; kill it.
          if_pc_s       = pc_r;
          if_pc_plus4_s = pc_plus4_s;
          if_valid_s    = 1'b0;
          pc_s          = target_aligned_s;
`endif
        end else if (stall) begin
          pc_s          = pc_r;
        end else begin
          if_pc_s       = pc_r;
          if_pc_plus4_s = pc_plus4_s;
          if_valid_s    = 1'b1;
          pc_s          = pc_plus4_s;
        end
      end
      default: begin
        pc_s = pc_r;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_VECTOR;
      if_pc_r       <= RESET_VECTOR;
      if_pc_plus4_r <= RESET_VECTOR + 32'd4;
      if_valid_r    <= 1'b0;
      fetch_fault_r <= 1'b0;
    end else begin
      pc_r          <= pc_s;
      if_pc_r       <= if_pc_s;
      if_pc_plus4_r <= if_pc_plus4_s;
      if_valid_r    <= if_valid_s;
      fetch_fault_r <= fetch_fault_s;
    end
  end

  assign pc          = pc_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;
  assign if_valid    = if_valid_r;
  assign fetch_fault = fetch_fault_r;

endmodule

// File: tb/tb_if_pc_unit.sv
// Self-checking bench for if_pc_unit: directed test-plan steps followed by random traffic
// against a behavioural fetch model; honours FETCH_MISALIGN_TRAP_EN when defined.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch pointer plus the instruction currently on the memory output.
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic        m_valid;
  logic        m_fault;
  bit          m_started;
  bit          m_halted;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  if_pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .pc(pc), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic s, input logic d, input logic [31:0] t);
    if (r) begin
      m_pc = 32'h0; m_if_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
      m_started = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (!m_started) begin
      if (!s) begin
        m_if_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_started = 1'b1;
      end
    end else if (d) begin
      if (TRAP && (t % 4 != 0)) begin
        m_halted = 1'b1; m_valid = 1'b0; m_fault = 1'b1;
      end else begin
        m_valid = 1'b0; m_pc = t - (t % 4);
      end
    end else if (!s) begin
      m_if_pc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst = r; stall = s; redirect = d; redirect_target = t;
    @(posedge clk);
    model_update(r, s, d, t);
    #1;
    check32("model_pc", pc, m_pc);
    check32("model_valid", {31'd0, if_valid}, {31'd0, m_valid});
    check32("model_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    if (m_valid) begin
      check32("model_if_pc", if_pc, m_if_pc);
      check32("model_if_pc_plus4", if_pc_plus4, m_if_pc + 32'd4);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0700);
    check32("rst_pc", pc, 32'h0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_plus4", if_pc_plus4, 32'h4);
    check32("rst_valid", {31'd0, if_valid}, 32'h0);
    check32("rst_fault", {31'd0, fetch_fault}, 32'h0);

    // Stall in BOOT holds; redirect there is ignored
    step(1'b0, 1'b1, 1'b1, 32'h0000_0500);
    check32("boot_stall_pc", pc, 32'h0);
    check32("boot_stall_valid", {31'd0, if_valid}, 32'h0);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("first_pc", pc, 32'h4);
    check32("first_if_pc", if_pc, 32'h0);
    check32("first_valid", {31'd0, if_valid}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("seq_pc", pc, 32'h10);
    check32("seq_if_pc", if_pc, 32'hC);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check32("stall_pc", pc, 32'h10);
      check32("stall_if_pc", if_pc, 32'hC);
      check32("stall_valid", {31'd0, if_valid}, 32'h1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("unstall_pc", pc, 32'h14);
    check32("unstall_if_pc", if_pc, 32'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("pre_redir_pc", pc, 32'h20);

    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    check32("redir_pc", pc, 32'h100);
    check32("redir_valid", {31'd0, if_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("redir_fetch_if_pc", if_pc, 32'h100);
    check32("redir_fetch_valid", {31'd0, if_valid}, 32'h1);
    check32("redir_fetch_pc", pc, 32'h104);

    step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    check32("redir_over_stall_pc", pc, 32'h40);
    check32("redir_over_stall_valid", {31'd0, if_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0080);
    check32("b2b_pc", pc, 32'h80);
    check32("b2b_valid", {31'd0, if_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("b2b_if_pc", if_pc, 32'h80);
    check32("b2b_fetch_valid", {31'd0, if_valid}, 32'h1);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("wrap_pc_fc", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("wrap_pc_0", pc, 32'h0);
    check32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check32("wrap_plus4", if_pc_plus4, 32'h0);

    step(1'b1, 1'b0, 1'b1, 32'h0000_0300);
    check32("midrst_pc", pc, 32'h0);
    check32("midrst_valid", {31'd0, if_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check32("rst_latency_valid", {31'd0, if_valid}, 32'h1);
    check32("rst_latency_pc", pc, 32'h4);

    step(1'b0, 1'b0, 1'b1, 32'h0000_0102);
    check32("misalign_pc", pc, TRAP ? 32'h4 : 32'h100);
    check32("misalign_fault", {31'd0, fetch_fault}, TRAP ? 32'h1 : 32'h0);
    check32("misalign_valid", {31'd0, if_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    check32("post_misalign_pc", pc, TRAP ? 32'h4 : 32'h200);
    check32("post_misalign_fault", {31'd0, fetch_fault}, TRAP ? 32'h1 : 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check32("fault_cleared", {31'd0, fetch_fault}, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t = t & 32'hFFFF_FFFC;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 6) == 0), t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
